// File: rtl/mips_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_lite_pkg
//  Description : Shared constants for the mips_lite single-cycle core:
//                instruction field positions, opcodes and ALU operations.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_lite_pkg;

    // Instruction field positions
    localparam int c_OP_HI    = 31;
    localparam int c_OP_LO    = 26;
    localparam int c_RS_HI    = 25;
    localparam int c_RS_LO    = 21;
    localparam int c_RT_HI    = 20;
    localparam int c_RT_LO    = 16;
    localparam int c_RD_HI    = 15;
    localparam int c_RD_LO    = 11;
    localparam int c_SH_HI    = 10;
    localparam int c_SH_LO    = 6;
    localparam int c_IMM_HI   = 15;
    localparam int c_IMM_LO   = 0;

    localparam int c_REG_ADDR_W = 5;
    localparam int c_NUM_REGS   = 32;
    localparam int c_IMM_W      = 16;
    localparam int c_SHAMT_W    = 5;

    // Opcodes
    localparam logic [5:0] c_OP_ADD  = 6'b000001;
    localparam logic [5:0] c_OP_SUB  = 6'b000010;
    localparam logic [5:0] c_OP_INC  = 6'b000011;
    localparam logic [5:0] c_OP_DEC  = 6'b000100;
    localparam logic [5:0] c_OP_AND  = 6'b000101;
    localparam logic [5:0] c_OP_OR   = 6'b000110;
    localparam logic [5:0] c_OP_XOR  = 6'b000111;
    localparam logic [5:0] c_OP_NOT  = 6'b001000;
    localparam logic [5:0] c_OP_SLL  = 6'b001001;
    localparam logic [5:0] c_OP_SRL  = 6'b001010;
    localparam logic [5:0] c_OP_ADDI = 6'b001011;
    localparam logic [5:0] c_OP_SUBI = 6'b001100;
    localparam logic [5:0] c_OP_CMP  = 6'b001101;
    localparam logic [5:0] c_OP_LW   = 6'b100010;
    localparam logic [5:0] c_OP_SW   = 6'b100100;

    // ALU operations. NOP drives a zero result so an unknown opcode
    // naturally produces data_out = 0.
    typedef enum logic [3:0] {
        c_ALU_NOP = 4'd0,
        c_ALU_ADD = 4'd1,
        c_ALU_SUB = 4'd2,
        c_ALU_AND = 4'd3,
        c_ALU_OR  = 4'd4,
        c_ALU_XOR = 4'd5,
        c_ALU_NOT = 4'd6,
        c_ALU_SLL = 4'd7,
        c_ALU_SRL = 4'd8,
        c_ALU_INC = 4'd9,
        c_ALU_DEC = 4'd10,
        c_ALU_SLT = 4'd11
    } alu_ctrl_e;

    // Three-register format: destination comes from the rd field
    function automatic logic is_r_type(input logic [5:0] op);
        return (op == c_OP_ADD) || (op == c_OP_SUB) || (op == c_OP_AND) ||
               (op == c_OP_OR)  || (op == c_OP_XOR) || (op == c_OP_CMP);
    endfunction

endpackage : mips_lite_pkg
`default_nettype wire

// File: rtl/mips_lite_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_lite_ctrl
//  Description : Opcode decoder producing the datapath control signals.
//                Unknown opcodes leave every control deasserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_lite_ctrl
    import mips_lite_pkg::*;
(
    input  logic [5:0]  i_op,
    output logic        o_reg_dst,
    output logic        o_reg_write,
    output logic        o_alu_src,
    output alu_ctrl_e   o_alu_ctrl,
    output logic        o_mem_write,
    output logic        o_mem_read,
    output logic        o_mem_to_reg,
    output logic        o_shamt_sel
);

    // Pure combinational decode; defaults describe the "do nothing" instruction
    always_comb begin
        o_reg_dst    = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src    = 1'b0;
        o_alu_ctrl   = c_ALU_NOP;
        o_mem_write  = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_to_reg = 1'b0;
        o_shamt_sel  = 1'b0;

        case (i_op)
            c_OP_ADD:  begin o_reg_write = 1'b1; o_alu_ctrl = c_ALU_ADD; end
            c_OP_SUB:  begin o_reg_write = 1'b1; o_alu_ctrl = c_ALU_SUB; end
            c_OP_AND:  begin o_reg_write = 1'b1; o_alu_ctrl = c_ALU_AND; end
            c_OP_OR:   begin o_reg_write = 1'b1; o_alu_ctrl = c_ALU_OR;  end
            c_OP_XOR:  begin o_reg_write = 1'b1; o_alu_ctrl = c_ALU_XOR; end
            c_OP_CMP:  begin o_reg_write = 1'b1; o_alu_ctrl = c_ALU_SLT; end
            c_OP_INC:  begin o_reg_write = 1'b1; o_alu_ctrl = c_ALU_INC; end
            c_OP_DEC:  begin o_reg_write = 1'b1; o_alu_ctrl = c_ALU_DEC; end
            c_OP_NOT:  begin o_reg_write = 1'b1; o_alu_ctrl = c_ALU_NOT; end
            c_OP_SLL:  begin
                o_reg_write = 1'b1;
                o_alu_ctrl  = c_ALU_SLL;
                o_shamt_sel = 1'b1;
            end
            c_OP_SRL:  begin
                o_reg_write = 1'b1;
                o_alu_ctrl  = c_ALU_SRL;
                o_shamt_sel = 1'b1;
            end
            c_OP_ADDI: begin
                o_reg_write = 1'b1;
                o_alu_src   = 1'b1;
                o_alu_ctrl  = c_ALU_ADD;
            end
            c_OP_SUBI: begin
                o_reg_write = 1'b1;
                o_alu_src   = 1'b1;
                o_alu_ctrl  = c_ALU_SUB;
            end
            c_OP_LW:   begin
                o_reg_write  = 1'b1;
                o_alu_src    = 1'b1;
                o_alu_ctrl   = c_ALU_ADD;
                o_mem_read   = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            c_OP_SW:   begin
                o_alu_src   = 1'b1;
                o_alu_ctrl  = c_ALU_ADD;
                o_mem_write = 1'b1;
            end
            default: ;
        endcase

        o_reg_dst = is_r_type(i_op);
    end

endmodule : mips_lite_ctrl
`default_nettype wire

// File: rtl/mips_lite_core.sv
`default_nettype none
// ============================================================================
//  Module      : mips_lite_core
//  Description : Single-cycle 32-bit execution core. The instruction word is
//                applied externally each cycle; operands are read and the
//                result computed combinationally, state commits on clk rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_lite_core
    import mips_lite_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] data_out
);

    localparam int c_ADDR_W = $clog2(MEM_DEPTH);

    // Architectural state
    logic [DATA_W-1:0] r_regs [c_NUM_REGS];
    logic [DATA_W-1:0] r_mem  [MEM_DEPTH];

    // Instruction fields
    logic [5:0]              w_op;
    logic [c_REG_ADDR_W-1:0] w_rs;
    logic [c_REG_ADDR_W-1:0] w_rt;
    logic [c_REG_ADDR_W-1:0] w_rd;
    logic [c_SHAMT_W-1:0]    w_shamt;
    logic [c_IMM_W-1:0]      w_imm;

    assign w_op    = instr[c_OP_HI:c_OP_LO];
    assign w_rs    = instr[c_RS_HI:c_RS_LO];
    assign w_rt    = instr[c_RT_HI:c_RT_LO];
    assign w_rd    = instr[c_RD_HI:c_RD_LO];
    assign w_shamt = instr[c_SH_HI:c_SH_LO];
    assign w_imm   = instr[c_IMM_HI:c_IMM_LO];

    // Control
    logic      w_reg_dst;
    logic      w_reg_write;
    logic      w_alu_src;
    alu_ctrl_e w_alu_ctrl;
    logic      w_mem_write;
    logic      w_mem_read;
    logic      w_mem_to_reg;
    logic      w_shamt_sel;

    mips_lite_ctrl u_ctrl (
        .i_op         (w_op),
        .o_reg_dst    (w_reg_dst),
        .o_reg_write  (w_reg_write),
        .o_alu_src    (w_alu_src),
        .o_alu_ctrl   (w_alu_ctrl),
        .o_mem_write  (w_mem_write),
        .o_mem_read   (w_mem_read),
        .o_mem_to_reg (w_mem_to_reg),
        .o_shamt_sel  (w_shamt_sel)
    );

    // Operand fetch and selection
    logic [DATA_W-1:0]       w_rs_val;
    logic [DATA_W-1:0]       w_rt_val;
    logic [DATA_W-1:0]       w_imm_sext;
    logic [DATA_W-1:0]       w_shamt_ext;
    logic [DATA_W-1:0]       w_alu_a;
    logic [DATA_W-1:0]       w_alu_b;
    logic [c_REG_ADDR_W-1:0] w_dst;

    assign w_rs_val    = r_regs[w_rs];
    assign w_rt_val    = r_regs[w_rt];
    assign w_imm_sext  = {{(DATA_W-c_IMM_W){w_imm[c_IMM_W-1]}}, w_imm};
    assign w_shamt_ext = {{(DATA_W-c_SHAMT_W){1'b0}}, w_shamt};
    assign w_alu_a     = w_rs_val;
    assign w_alu_b     = w_alu_src   ? w_imm_sext  :
                         w_shamt_sel ? w_shamt_ext : w_rt_val;
    assign w_dst       = w_reg_dst ? w_rd : w_rt;

    // ALU: all arithmetic wraps modulo 2^DATA_W, no flags
    logic [DATA_W-1:0] w_alu_y;

    always_comb begin
        w_alu_y = '0;
        case (w_alu_ctrl)
            c_ALU_ADD: w_alu_y = w_alu_a + w_alu_b;
            c_ALU_SUB: w_alu_y = w_alu_a - w_alu_b;
            c_ALU_AND: w_alu_y = w_alu_a & w_alu_b;
            c_ALU_OR:  w_alu_y = w_alu_a | w_alu_b;
            c_ALU_XOR: w_alu_y = w_alu_a ^ w_alu_b;
            c_ALU_NOT: w_alu_y = ~w_alu_a;
            c_ALU_SLL: w_alu_y = w_alu_a << w_alu_b[c_SHAMT_W-1:0];
            c_ALU_SRL: w_alu_y = w_alu_a >> w_alu_b[c_SHAMT_W-1:0];
            c_ALU_INC: w_alu_y = w_alu_a + {{(DATA_W-1){1'b0}}, 1'b1};
            c_ALU_DEC: w_alu_y = w_alu_a - {{(DATA_W-1){1'b0}}, 1'b1};
            c_ALU_SLT: w_alu_y = {{(DATA_W-1){1'b0}},
                                  ($signed(w_alu_a) < $signed(w_alu_b))};
            default:   w_alu_y = '0;
        endcase
    end

    // Data memory: word address is the low bits of the effective address
    logic [c_ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0]   w_mem_rdata;

    assign w_mem_addr  = w_alu_y[c_ADDR_W-1:0];
    assign w_mem_rdata = w_mem_read ? r_mem[w_mem_addr] : '0;

    // Write-back value, also the externally visible result
    logic [DATA_W-1:0] w_wb;

    assign w_wb     = w_mem_to_reg ? w_mem_rdata : w_alu_y;
    assign data_out = w_wb;

    // Register file write port; reads see the pre-edge value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_write) begin
            r_regs[w_dst] <= w_wb;
        end
    end

    // Data memory write port; reset loads each word with its own index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= DATA_W'(i);
            end
        end else if (w_mem_write) begin
            r_mem[w_mem_addr] <= w_rt_val;
        end
    end

endmodule : mips_lite_core
`default_nettype wire

// File: tb/tb_mips_lite_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_lite_core
//  Description : Self-checking bench for mips_lite_core: directed sequence
//                with literal expectations, randomized instruction stream
//                against an architectural model, and a mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_lite_core;

    localparam logic [5:0] ADD  = 6'b000001, SUB  = 6'b000010,
                           INC  = 6'b000011, DEC  = 6'b000100,
                           AND_ = 6'b000101, OR_  = 6'b000110,
                           XOR_ = 6'b000111, NOT_ = 6'b001000,
                           SLL  = 6'b001001, SRL  = 6'b001010,
                           ADDI = 6'b001011, SUBI = 6'b001100,
                           CMP  = 6'b001101, LW   = 6'b100010,
                           SW   = 6'b100100, BAD  = 6'b111111;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    mips_lite_core #(.DATA_W(32), .MEM_DEPTH(256)) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- architectural model ----------------
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [256];

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // What the instruction produces, straight from the ISA rules
    function automatic logic [31:0] model_out(input logic [31:0] w);
        logic [31:0] a, b, ea;
        a  = m_reg[w[25:21]];
        b  = m_reg[w[20:16]];
        ea = a + sx(w[15:0]);
        case (w[31:26])
            ADD:  return a + b;
            SUB:  return a - b;
            AND_: return a & b;
            OR_:  return a | b;
            XOR_: return a ^ b;
            CMP:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            INC:  return a + 32'd1;
            DEC:  return a - 32'd1;
            NOT_: return ~a;
            SLL:  return a << w[10:6];
            SRL:  return a >> w[10:6];
            ADDI: return ea;
            SUBI: return a - sx(w[15:0]);
            LW:   return m_mem[ea % 256];
            SW:   return ea;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)  m_reg[i] = 32'd0;
            for (int i = 0; i < 256; i++) m_mem[i] = i;
        end else begin
            logic [31:0] res;
            logic [5:0]  op;
            res = model_out(instr);
            op  = instr[31:26];
            if (op == SW)
                m_mem[(m_reg[instr[25:21]] + sx(instr[15:0])) % 256] = m_reg[instr[20:16]];
            else if (op == ADD || op == SUB || op == AND_ || op == OR_ || op == XOR_ || op == CMP)
                m_reg[instr[15:11]] = res;
            else if (op inside {INC, DEC, NOT_, SLL, SRL, ADDI, SUBI, LW})
                m_reg[instr[20:16]] = res;
        end
    end

    // Every cycle out of reset, data_out must match the model
    always @(negedge clk) begin
        if (!rst) begin
            logic [31:0] exp_v;
            exp_v = model_out(instr);
            n_cmp++;
            if (data_out !== exp_v) begin
                n_fail++;
                $display("FAIL data_out instr=%h: got %h expected %h", instr, data_out, exp_v);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] rt_(input logic [5:0] op, input int rs, input int rt,
                                        input int rd, input int sh);
        logic [4:0] s, t, d, h;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0]; h = sh[4:0];
        return {op, s, t, d, h, 6'b000000};
    endfunction

    function automatic logic [31:0] it_(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0]; t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    task automatic issue(input logic [31:0] w);
        @(posedge clk);
        #1 instr = w;
    endtask

    // Literal expectation for the instruction currently applied
    task automatic lit(input string name, input logic [31:0] exp_v);
        @(negedge clk);
        #1;
        n_cmp++;
        if (data_out !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, data_out, exp_v);
        end
    endtask

    // Read a register through data_out without changing it (ADDI r,r,0)
    task automatic peek(input string name, input int r, input logic [31:0] exp_v);
        issue(it_(ADDI, r, r, 16'h0000));
        lit(name, exp_v);
    endtask

    logic [5:0] ops [17] = '{ADD, SUB, INC, DEC, AND_, OR_, XOR_, NOT_, SLL, SRL,
                             ADDI, SUBI, CMP, LW, SW, BAD, 6'b000000};

    initial begin
        rst   = 1'b1;
        instr = 32'h0000_0000;
        repeat (2) @(posedge clk);
        lit("reset_unknown_op_zero", 32'd0);
        #2 rst = 1'b0;
        peek("reset_r0", 0, 32'd0);

        issue(it_(LW, 1, 0, 16'd1));   lit("lw_r0", 32'd1);
        issue(it_(LW, 2, 1, 16'd1));   lit("lw_r1", 32'd1);
        issue(rt_(ADD, 0, 1, 3, 0));   lit("add_r3", 32'd2);
        peek("r3", 3, 32'd2);

        issue(it_(LW, 2, 4, 16'd10));  lit("lw_r4", 32'd10);
        issue(it_(LW, 2, 5, 16'd9));   lit("lw_r5", 32'd9);
        issue(rt_(SUB, 4, 5, 6, 0));   lit("sub_r6", 32'd1);
        issue(it_(LW, 2, 7, 16'd4));
        issue(it_(INC, 7, 9, 16'd0));  lit("inc_r9", 32'd5);
        issue(it_(LW, 2, 8, 16'd5));
        issue(it_(DEC, 8, 10, 16'd0)); lit("dec_r10", 32'd4);
        issue(it_(LW, 2, 11, 16'd5));
        issue(rt_(SLL, 11, 12, 0, 2)); lit("sll_r12", 32'd20);
        issue(it_(LW, 2, 13, 16'd8));
        issue(rt_(SRL, 13, 14, 0, 2)); lit("srl_r14", 32'd2);
        peek("r12", 12, 32'd20);

        issue(it_(LW, 2, 2, 16'd2));   lit("lw_r2", 32'd2);
        issue(rt_(AND_, 2, 1, 15, 0)); lit("and", 32'd0);
        issue(rt_(OR_, 2, 1, 15, 0));  lit("or", 32'd3);
        issue(rt_(XOR_, 2, 3, 15, 0)); lit("xor", 32'd0);
        issue(it_(NOT_, 2, 15, 16'd0)); lit("not", 32'hFFFF_FFFD);
        issue(it_(ADDI, 2, 15, 16'd1)); lit("addi", 32'd3);
        issue(it_(SUBI, 2, 15, 16'd1)); lit("subi", 32'd1);
        issue(rt_(CMP, 2, 1, 15, 0));  lit("cmp_gt", 32'd0);
        issue(rt_(CMP, 1, 2, 15, 0));  lit("cmp_lt", 32'd1);
        issue(it_(NOT_, 2, 16, 16'd0));
        issue(rt_(CMP, 16, 1, 15, 0)); lit("cmp_signed_neg", 32'd1);

        // r0 is 1 here, so r0+7 addresses word 8
        issue(it_(SW, 0, 3, 16'd7));   lit("sw_ea", 32'd8);
        issue(it_(LW, 0, 20, 16'd7));  lit("lw_after_sw", 32'd2);
        peek("sw_no_reg_change_r3", 3, 32'd2);
        issue(it_(ADDI, 3, 16, 16'hFFFF)); lit("addi_neg_imm", 32'd1);
        issue(it_(LW, 2, 17, 16'd298)); lit("lw_wrap_44", 32'd44);
        issue(it_(SW, 2, 3, 16'd298)); lit("sw_wrap_ea", 32'd300);
        issue(it_(LW, 2, 18, 16'd42)); lit("lw_word44", 32'd2);

        // Randomized stream, checked every cycle by the model
        for (int k = 0; k < 400; k++) begin
            logic [5:0]  op;
            logic [31:0] w;
            op = ops[$urandom_range(16, 0)];
            w  = $urandom;
            w[31:26] = op;
            issue(w);
        end

        // Asynchronous reset in the middle of a cycle, with a store pending
        issue(it_(SW, 2, 3, 16'd3));
        #2 rst = 1'b1;
        instr = {BAD, 26'h0};
        @(posedge clk);
        #3 rst = 1'b0;
        issue(it_(LW, 0, 1, 16'd3));   lit("post_reset_lw", 32'd3);
        issue({BAD, 26'h3FF_FFFF});    lit("unknown_op_zero", 32'd0);
        peek("unknown_keeps_r1", 1, 32'd3);
        peek("post_reset_r5", 5, 32'd0);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mips_lite_core
`default_nettype wire
